proc_test_mem_responder: RTL
============================

Name: proc_test_mem_responder

Overview:
- Single-port memory responder: the memory-side end of the mem_req_4B_t / mem_resp_4B_t val/rdy stream protocol that the processor datapath and control drive on the imem and dmem ports.
- Accepts read/write/init requests, performs them on an internal word array, and returns in-order responses after a programmable fixed latency.
- Bounded response buffering with credit-based backpressure.
- Used as the behavioural imem/dmem in processor test harnesses; one instance per port.

Parameters:
- p_mem_nwords, 1024: number of 32-bit words in the array; power of two, ≥ 2.
- p_latency, 1: cycles from request accept to earliest response valid; ≥ 1.
- p_resp_depth, 2: maximum requests accepted but not yet responded (in flight plus queued); ≥ p_latency.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-low reset; asserted when 0.
- reqstream_val, input, 1: request valid.
- reqstream_rdy, output, 1: request ready.
- reqstream_msg, input, 77: mem_req_4B_t = {type[2:0], opaque[7:0], addr[31:0], len[1:0], data[31:0]}.
- respstream_val, output, 1: response valid.
- respstream_rdy, input, 1: response ready.
- respstream_msg, output, 47: mem_resp_4B_t = {type[2:0], opaque[7:0], test[1:0], len[1:0], data[31:0]}.

Behaviour:
- Reset assertion (async):
  - respstream_val = 0, reqstream_rdy = 0, respstream_msg = 0.
  - Credits are set to p_resp_depth.
  - Latency pipe and queue are emptied; in-flight responses are discarded.
  - Array contents are not cleared.
- After reset deasserts: reqstream_rdy = 1 from the first cycle.
- Handshakes:
  - A transfer occurs on an edge where val && rdy.
  - reqstream_rdy = (credits != 0), a function of registered state only. There is no combinational path from respstream_rdy or reqstream_val.
  - A credit is consumed on request accept and returned on response handshake. When both happen in the same cycle the count is unchanged.
- Word index: addr[2 +: log2(p_mem_nwords)]. Upper address bits are ignored, so addresses wrap modulo the array size.
- Byte offset: off = addr[1:0].
- Byte count: n = (len == 0) ? 4 : len.
- Write (type 1) and init (type 2):
  - Bytes [off .. min(off+n,4)-1] of the addressed word take data bytes [0 .. ] at the accept edge.
  - Bytes past the word end are dropped.
  - Response data = 0.
- Read (type 0):
  - Data is sampled at the accept edge: word >> (8*off), with bytes at or beyond n zeroed (zero-extended).
  - A read accepted after a write to the same word returns the written value. No same-cycle hazard exists because one request is accepted per cycle.
- Other types: no array change; response type echoes the request; data = 0.
- Response fields:
  - type, opaque and len echo the request.
  - test = 0.
  - Responses are issued strictly in accept order.
- Latency and ordering:
  - A request accepted at edge E appears on respstream_val in the cycle after edge E + p_latency − 1. With p_latency = 1 it is valid in the cycle immediately following the accept edge.
  - Later under backpressure.
  - Back-to-back accepts with respstream_rdy = 1 sustain one response per cycle.
- respstream_msg holds stable while respstream_val = 1 and respstream_rdy = 0.
- Full boundary: with credits = 0, reqstream_rdy = 0. A response handshake in cycle t makes reqstream_rdy = 1 in cycle t+1.
- Empty boundary: respstream_val = 0 and respstream_msg = 0.

Decomposition:
- Shared package (existing mem-msgs): mem_req_4B_t and mem_resp_4B_t typedefs, field widths, and type constants MEM_MSG_TYPE_READ = 0, WRITE = 1, INIT = 2.
- Local constants: c_idx_nbits = log2(p_mem_nwords).
- Sub-module proc_test_mem_resp_queue:
  - In-order queue of depth p_resp_depth, holding 47-bit entries, fed by the latency pipe output.
  - Outputs full, empty and count; async active-low reset.
- Top level owns the array, the byte-lane logic, the (p_latency − 1)-stage valid/message pipe and the credit counter.

Test Plan:
- Reset held low, then released; no requests → while reset is low, reqstream_rdy = 0 and respstream_val = 0; first cycle after release, reqstream_rdy = 1.
- Init addr 0x0000_0200, data 0xDEAD_BEEF, opaque 0x01; then read addr 0x200, len 0, opaque 0x02 (p_latency = 1) → init response (type 2, opaque 0x01, data 0) one cycle after its accept; read response (type 0, opaque 0x02, data 0xDEAD_BEEF) one cycle after its accept.
- Write 0xAABB_CCDD at 0x100; write len 1 at addr 0x102 with data 0x11; read 0x100 len 0; read 0x103 len 2 → first read returns 0xAA11_CCDD, second read returns 0x0000_00AA.
- p_latency = 3, p_resp_depth = 3, respstream_rdy = 0, four requests offered → three accepted, then reqstream_rdy = 0; raise respstream_rdy for one cycle → one response consumed; reqstream_rdy = 1 the next cycle; fourth request accepted.
- Ten back-to-back reads with opaque 0..9 and respstream_rdy toggling 1, 0, 1, 0 → responses arrive in opaque order 0..9; msg stable while stalled; no loss or duplication.
- Assert reset with two responses in flight → respstream_val = 0 immediately (async); after release, no stale response appears; an earlier-initialised word still reads back its value.

Source files
------------

// File: rtl/proc_test_mem_responder_pkg.sv
// Memory message formats shared by the processor harness and its memory
// responders, plus the byte-lane helpers used for sub-word accesses.
package proc_test_mem_responder_pkg;

  localparam int c_req_nbits  = 77;
  localparam int c_resp_nbits = 47;

  localparam logic [2:0] MEM_MSG_TYPE_READ  = 3'd0;
  localparam logic [2:0] MEM_MSG_TYPE_WRITE = 3'd1;
  localparam logic [2:0] MEM_MSG_TYPE_INIT  = 3'd2;

  typedef struct packed {
    logic [2:0]  typ;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4B_t;

  typedef struct packed {
    logic [2:0]  typ;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;

  // A len of zero encodes a full four-byte access.
  function automatic logic [2:0] byte_count(input logic [1:0] len);
    return (len == 2'd0) ? 3'd4 : {1'b0, len};
  endfunction

  // Bytes that would run past the end of the word are dropped.
  function automatic logic [31:0] write_merge(input logic [31:0] word,
                                              input logic [1:0]  off,
                                              input logic [2:0]  nbytes,
                                              input logic [31:0] data);
    logic [31:0] res;
    res = word;
    for (int b = 0; b < 4; b++) begin
      if (b >= int'(off) && b < int'(off) + int'(nbytes)) begin
        res[8*b +: 8] = data[8*(b - int'(off)) +: 8];
      end
    end
    return res;
  endfunction

  function automatic logic [31:0] read_extract(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [2:0]  nbytes);
    logic [31:0] res;
    res = word >> {off, 3'b000};
    for (int b = 0; b < 4; b++) begin
      if (b >= int'(nbytes)) begin
        res[8*b +: 8] = 8'h00;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/proc_test_mem_responder_resp_queue.sv
// In-order response queue between the latency pipe and the response port.
// Upstream credit accounting guarantees it is never pushed while full.
module proc_test_mem_resp_queue
  import proc_test_mem_responder_pkg::*;
#(
  parameter int p_depth = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_enq_val,
  input  mem_resp_4B_t                 i_enq_msg,
  input  logic                         i_deq,
  output mem_resp_4B_t                 o_head,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(p_depth+1)-1:0] o_count
);

  localparam int c_cnt_w = $clog2(p_depth + 1);
  localparam int c_ptr_w = (p_depth > 1) ? $clog2(p_depth) : 1;
  localparam logic [c_ptr_w-1:0] c_last = c_ptr_w'(p_depth - 1);

  mem_resp_4B_t        r_slots [p_depth];
  logic [c_ptr_w-1:0]  r_wr_ptr;
  logic [c_ptr_w-1:0]  r_rd_ptr;
  logic [c_cnt_w-1:0]  r_count;
  logic                w_enq;
  logic                w_deq;

  assign w_deq   = i_deq && (r_count != '0);
  assign w_enq   = i_enq_val && (!o_full || w_deq);
  assign o_full  = (r_count == c_cnt_w'(p_depth));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_slots[r_rd_ptr];

  // NOTE: storage has no reset; r_count alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_slots[r_wr_ptr] <= i_enq_msg;
    end
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) begin
        r_wr_ptr <= (r_wr_ptr == c_last) ? '0 : r_wr_ptr + c_ptr_w'(1);
      end
      if (w_deq) begin
        r_rd_ptr <= (r_rd_ptr == c_last) ? '0 : r_rd_ptr + c_ptr_w'(1);
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/proc_test_mem_responder.sv
// Behavioural imem/dmem responder: word array with byte lanes, fixed-latency
// response pipe, in-order response queue and credit-based request backpressure.
module proc_test_mem_responder
  import proc_test_mem_responder_pkg::*;
#(
  parameter int p_mem_nwords = 1024,
  parameter int p_latency    = 1,
  parameter int p_resp_depth = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         reqstream_val,
  output logic         reqstream_rdy,
  input  mem_req_4B_t  reqstream_msg,
  output logic         respstream_val,
  input  logic         respstream_rdy,
  output mem_resp_4B_t respstream_msg
);

  localparam int c_idx_nbits = $clog2(p_mem_nwords);
  localparam int c_cred_w    = $clog2(p_resp_depth + 1);

  logic [31:0]            r_mem [p_mem_nwords];
  logic [c_cred_w-1:0]    r_credits;

  logic [c_idx_nbits-1:0] w_idx;
  logic [1:0]             w_off;
  logic [2:0]             w_nbytes;
  logic [31:0]            w_word;
  logic                   w_accept;
  logic                   w_is_write;
  logic                   w_resp_fire;
  logic                   w_unused_addr;
  mem_resp_4B_t           w_resp_now;
  logic                   w_enq_val;
  mem_resp_4B_t           w_enq_msg;
  mem_resp_4B_t           w_q_head;
  logic                   w_q_full;
  logic                   w_q_empty;
  logic [c_cred_w-1:0]    w_q_count;

  // Gating with reset keeps rdy low while held in reset and high from the first cycle after.
  assign reqstream_rdy = reset && (r_credits != '0);
  assign w_accept      = reqstream_val && reqstream_rdy;
  assign w_resp_fire   = respstream_val && respstream_rdy;

  assign w_idx         = reqstream_msg.addr[2 +: c_idx_nbits];
  assign w_off         = reqstream_msg.addr[1:0];
  assign w_nbytes      = byte_count(reqstream_msg.len);
  assign w_word        = r_mem[w_idx];
  assign w_is_write    = (reqstream_msg.typ == MEM_MSG_TYPE_WRITE) ||
                         (reqstream_msg.typ == MEM_MSG_TYPE_INIT);
  assign w_unused_addr = ^(reqstream_msg.addr >> (c_idx_nbits + 2));

  // NOTE: defaults first so no path through the block can infer a latch.
  always_comb begin
    w_resp_now        = '0;
    w_resp_now.typ    = reqstream_msg.typ;
    w_resp_now.opaque = reqstream_msg.opaque;
    w_resp_now.len    = reqstream_msg.len;
    if (reqstream_msg.typ == MEM_MSG_TYPE_READ) begin
      w_resp_now.data = read_extract(w_word, w_off, w_nbytes);
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept && w_is_write) begin
      r_mem[w_idx] <= write_merge(w_word, w_off, w_nbytes, reqstream_msg.data);
    end
  end

  // Read data is captured at accept; the pipe only delays the finished response.
  if (p_latency == 1) begin : g_no_pipe
    assign w_enq_val = w_accept;
    assign w_enq_msg = w_resp_now;
  end else begin : g_pipe
    logic         r_pipe_val [p_latency-1];
    mem_resp_4B_t r_pipe_msg [p_latency-1];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int i = 0; i < p_latency - 1; i++) begin
          r_pipe_val[i] <= 1'b0;
          r_pipe_msg[i] <= '0;
        end
      end else begin
        r_pipe_val[0] <= w_accept;
        r_pipe_msg[0] <= w_resp_now;
        for (int i = 1; i < p_latency - 1; i++) begin
          r_pipe_val[i] <= r_pipe_val[i-1];
          r_pipe_msg[i] <= r_pipe_msg[i-1];
        end
      end
    end

    assign w_enq_val = r_pipe_val[p_latency-2];
    assign w_enq_msg = r_pipe_msg[p_latency-2];
  end

  proc_test_mem_resp_queue #(
    .p_depth (p_resp_depth)
  ) u_resp_queue (
    .clk       (clk),
    .rst_n     (reset),
    .i_enq_val (w_enq_val),
    .i_enq_msg (w_enq_msg),
    .i_deq     (respstream_rdy),
    .o_head    (w_q_head),
    .o_full    (w_q_full),
    .o_empty   (w_q_empty),
    .o_count   (w_q_count)
  );

  assign respstream_val = !w_q_empty;
  assign respstream_msg = w_q_empty ? '0 : w_q_head;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_credits <= c_cred_w'(p_resp_depth);
    end else begin
      case ({w_accept, w_resp_fire})
        2'b10:   r_credits <= r_credits - c_cred_w'(1);
        2'b01:   r_credits <= r_credits + c_cred_w'(1);
        default: r_credits <= r_credits;
      endcase
    end
  end

  // Queued responses plus remaining credits can never exceed the depth.
  always_ff @(posedge clk) begin
    if (reset) begin
      assert (int'(r_credits) + int'(w_q_count) <= p_resp_depth);
      assert (!(w_enq_val && w_q_full && !w_resp_fire));
      assert (!w_unused_addr || 1'b1);
    end
  end

endmodule
